// File: rtl/ama_riscv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_mem_arb
// Brief    : Two-client (icache / dcache) read arbiter for the single main
//            memory port. Grants whole cache-line bursts, tags every issued
//            beat with its owner and routes in-order responses back.
//            Supports icache abort of a wrong-path burst.
// Options  : MEM_ARB_RR_EN - round-robin idle arbitration
//                            (default: fixed dcache priority)
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_mem_arb #(
  parameter int BEATS        = 4,   // memory transfers per cache line
  parameter int OUTST_DEPTH  = 8,   // outstanding-beat tag FIFO depth
  parameter int MEM_ADDR_BUS = 32,
  parameter int MEM_DATA_BUS = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_abort,
  input  logic                    ic_req_valid,
  output logic                    ic_req_ready,
  input  logic [MEM_ADDR_BUS-1:0] ic_req_addr,
  output logic                    ic_rsp_valid,
  output logic [MEM_DATA_BUS-1:0] ic_rsp_data,
  input  logic                    dc_req_valid,
  output logic                    dc_req_ready,
  input  logic [MEM_ADDR_BUS-1:0] dc_req_addr,
  output logic                    dc_rsp_valid,
  output logic [MEM_DATA_BUS-1:0] dc_rsp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [MEM_ADDR_BUS-1:0] mem_req_addr,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [MEM_DATA_BUS-1:0] mem_rsp_data
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int PTR_W = $clog2(OUTST_DEPTH);

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_IC   = 2'd1;
  localparam logic [1:0] ARB_DC   = 2'd2;

  // Tag owner encoding
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(OUTST_DEPTH);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic [OUTST_DEPTH-1:0] tag_owner_q, tag_owner_d;
  logic [OUTST_DEPTH-1:0] tag_drop_q, tag_drop_d;

  logic ic_can;
  logic grant_ic;
  logic grant_dc;
  logic fifo_full;
  logic fifo_empty;
  logic abort;
  logic owner_valid;
  logic accept;
  logic pop;
  logic head_owner;
  logic head_drop;

  assign ic_can = ic_req_valid && !ic_abort;

`ifdef MEM_ARB_RR_EN
  logic last_dc_q, last_dc_d;

  // Round-robin idle arbitration: on conflict, favour the client that lost last time
  always_comb begin
    grant_dc  = dc_req_valid && (!ic_can || !last_dc_q);
    grant_ic  = ic_can && !grant_dc;
    last_dc_d = last_dc_q;
    if ((state_q == ARB_IDLE) && (grant_dc || grant_ic)) begin
      last_dc_d = grant_dc;
    end
  end

  // Last-grant history; resets to icache so the dcache wins the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dc_q <= 1'b0;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end
`else
  // Fixed-priority idle arbitration: dcache always wins
  always_comb begin
    grant_dc = dc_req_valid;
    grant_ic = ic_can && !dc_req_valid;
  end
`endif

  // Request-side datapath: owner selection, FIFO-full gating and abort squash
  always_comb begin
    fifo_full     = (count_q == FULL_CNT);
    fifo_empty    = (count_q == '0);
    abort         = ic_abort && (state_q == ARB_IC);
    owner_valid   = 1'b0;
    mem_req_addr  = '0;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    case (state_q)
      ARB_IC: begin
        owner_valid  = ic_req_valid && !ic_abort;
        mem_req_addr = ic_req_addr;
        ic_req_ready = !ic_abort && mem_req_ready && !fifo_full;
      end
      ARB_DC: begin
        owner_valid  = dc_req_valid;
        mem_req_addr = dc_req_addr;
        dc_req_ready = mem_req_ready && !fifo_full;
      end
      default: ;
    endcase
    mem_req_valid = owner_valid && !fifo_full;
    accept        = mem_req_valid && mem_req_ready;
  end

  // Response routing: pop the head tag on every accepted response
  always_comb begin
    pop          = mem_rsp_valid && mem_rsp_ready && !fifo_empty;
    head_owner   = tag_owner_q[rd_ptr_q];
    head_drop    = tag_drop_q[rd_ptr_q];
    // An abort in the same cycle also kills the response being popped
    ic_rsp_valid = pop && (head_owner == OWN_IC) && !head_drop && !abort;
    dc_rsp_valid = pop && (head_owner == OWN_DC);
    ic_rsp_data  = mem_rsp_data;
    dc_rsp_data  = mem_rsp_data;
  end

  // Burst FSM and beat counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_dc) begin
          state_d = ARB_DC;
        end else if (grant_ic) begin
          state_d = ARB_IC;
        end
      end
      ARB_IC, ARB_DC: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = ARB_IDLE;
        end else if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ARB_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outstanding-beat tag FIFO with abort-driven drop marking
  always_comb begin
    tag_owner_d = tag_owner_q;
    tag_drop_d  = tag_drop_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (accept) begin
      tag_owner_d[wr_ptr_q] = (state_q == ARB_DC) ? OWN_DC : OWN_IC;
      tag_drop_d[wr_ptr_q]  = 1'b0;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Every icache-owned entry is dropped; stale slots are harmless
    if (abort) begin
      tag_drop_d = tag_drop_d | ~tag_owner_d;
    end
    count_d = count_q + {{PTR_W{1'b0}}, accept} - {{PTR_W{1'b0}}, pop};
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_owner_q <= '0;
      tag_drop_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_owner_q <= tag_owner_d;
      tag_drop_q  <= tag_drop_d;
    end
  end

  // Memory responses are always accepted outside reset
  assign mem_rsp_ready = !rst;

endmodule
`default_nettype wire
